// File: rtl/arm_regfile_sb.sv
// arm_regfile_sb: multi-read-port register file for the ID stage. Each register
// has a small counter of writes that are still in flight. The counters drive the
// read-after-write busy flags and the issue stall, so no separate hazard
// comparator chain is needed. Same-cycle writeback data can optionally be
// forwarded to the read ports.
module arm_regfile_sb #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int NUM_RD     = 3,
  parameter int CNT_W      = 2,
  parameter int BYPASS     = 1,
  parameter int RESET_MODE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_stall,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     flush
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [CNT_W-1:0]  r_cnt  [DEPTH];
  logic              w_stall;
  logic [DEPTH-1:0]  w_inc;
  logic [DEPTH-1:0]  w_dec;
  logic [ADDR_W-1:0] w_ra   [NUM_RD];
  logic [NUM_RD-1:0] w_hit;

  // Refuse an issue whose destination already has the maximum in-flight writes.
  always_comb begin
    w_stall = 1'b0;
    if (iss_en && (r_cnt[iss_addr] == CNT_MAX)) begin
      w_stall = 1'b1;
    end else begin
      w_stall = 1'b0;
    end
  end

  assign iss_stall = w_stall;

  // Per-register increment (accepted issue) and decrement (writeback of a pending result).
  always_comb begin
    w_inc = {DEPTH{1'b0}};
    w_dec = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      w_inc[i] = iss_en && (iss_addr == ADDR_W'(i)) && !w_stall;
      w_dec[i] = wb_en && (wb_addr == ADDR_W'(i)) && (r_cnt[i] != CNT_ZERO);
    end
  end

  // Register storage: reset pattern, then one writeback per cycle to any address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= (RESET_MODE == 1) ? DATA_W'(i) : {DATA_W{1'b0}};
      end
    end else if (wb_en) begin
      r_data[wb_addr] <= wb_data;
    end else begin
      r_data[wb_addr] <= r_data[wb_addr];
    end
  end

  // Pending-write counters: flush clears everything, issue and writeback on the same register cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_cnt[i] <= CNT_ZERO;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_cnt[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end else if (w_dec[i] && !w_inc[i]) begin
          r_cnt[i] <= r_cnt[i] - CNT_ONE;
        end else begin
          r_cnt[i] <= r_cnt[i];
        end
      end
    end
  end

  // Unpack read addresses and flag ports that see the current writeback.
  always_comb begin
    w_hit = {NUM_RD{1'b0}};
    for (int k = 0; k < NUM_RD; k++) begin
      w_ra[k]  = rd_addr[k*ADDR_W +: ADDR_W];
      w_hit[k] = (BYPASS == 1) && wb_en && (wb_addr == w_ra[k]);
    end
  end

  // Read data and busy per port; the forwarded last pending result clears busy
  // unless a fresh issue to the same register is being accepted this cycle.
  always_comb begin
    rd_data = {(NUM_RD*DATA_W){1'b0}};
    rd_busy = {NUM_RD{1'b0}};
    for (int k = 0; k < NUM_RD; k++) begin
      if (w_hit[k]) begin
        rd_data[k*DATA_W +: DATA_W] = wb_data;
      end else begin
        rd_data[k*DATA_W +: DATA_W] = r_data[w_ra[k]];
      end
      if (r_cnt[w_ra[k]] == CNT_ZERO) begin
        rd_busy[k] = 1'b0;
      end else if (w_hit[k] && (r_cnt[w_ra[k]] == CNT_ONE) && !w_inc[w_ra[k]]) begin
        rd_busy[k] = 1'b0;
      end else begin
        rd_busy[k] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arm_regfile_sb.sv
// Bench for arm_regfile_sb. Two instances run side by side, one with forwarding
// and one without, and both are driven with the same inputs. A reference model
// built from plain arrays predicts each cycle's outputs. The stimulus side
// pushes each prediction into a queue, and a monitor pops and compares it on
// the falling edge.
module tb_arm_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] rd_addr = 12'd0;
  logic [95:0] rd_data_b, rd_data_n;
  logic [2:0]  rd_busy_b, rd_busy_n;
  logic        iss_en = 1'b0;
  logic [3:0]  iss_addr = 4'd0;
  logic        stall_b, stall_n;
  logic        wb_en = 1'b0;
  logic [3:0]  wb_addr = 4'd0;
  logic [31:0] wb_data = 32'd0;
  logic        flush = 1'b0;

  arm_regfile_sb #(.BYPASS(1), .RESET_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_stall(stall_b),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush));

  arm_regfile_sb #(.BYPASS(0), .RESET_MODE(1)) dut_n (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_stall(stall_n),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush));

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] d_b;
    logic [95:0] d_n;
    logic [2:0]  bz_b;
    logic [2:0]  bz_n;
    logic        st;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] m_data [16];
  int          m_cnt  [16];

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp, input int c);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_data[i] = 32'(i);
      m_cnt[i]  = 0;
    end
  endtask

  // Predict this cycle's outputs, queue them, then apply the clock edge to the model.
  task automatic step();
    exp_t e;
    int   a;
    int   old_wb;
    logic acc;
    logic hit;
    e.st = iss_en && (m_cnt[iss_addr] == 3);
    acc  = iss_en && !e.st;
    for (int k = 0; k < 3; k++) begin
      a   = int'(rd_addr[k*4 +: 4]);
      hit = wb_en && (int'(wb_addr) == a);
      e.d_n[k*32 +: 32] = m_data[a];
      e.d_b[k*32 +: 32] = hit ? wb_data : m_data[a];
      e.bz_n[k] = (m_cnt[a] != 0);
      e.bz_b[k] = (m_cnt[a] != 0) && !(hit && m_cnt[a] == 1 && !(acc && int'(iss_addr) == a));
    end
    e.cyc = cyc;
    q.push_back(e);
    @(posedge clk);
    if (rst) begin
      if (wb_en) m_data[wb_addr] = wb_data;
      if (flush) begin
        for (int i = 0; i < 16; i++) m_cnt[i] = 0;
      end else begin
        old_wb = m_cnt[wb_addr];
        if (acc) m_cnt[iss_addr] = m_cnt[iss_addr] + 1;
        if (wb_en && old_wb != 0) m_cnt[wb_addr] = m_cnt[wb_addr] - 1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic drive(input logic ie, input logic [3:0] ia, input logic we, input logic [3:0] wa,
                       input logic [31:0] wd, input logic fl,
                       input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2);
    iss_en = ie; iss_addr = ia; wb_en = we; wb_addr = wa; wb_data = wd; flush = fl;
    rd_addr = {r2, r1, r0};
    step();
  endtask

  // Monitor: compare each queued prediction with what both instances present.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("rd_data_bypass",  rd_data_b,        mon_e.d_b,         mon_e.cyc);
        chk("rd_data_nobyp",   rd_data_n,        mon_e.d_n,         mon_e.cyc);
        chk("rd_busy_bypass",  96'(rd_busy_b),   96'(mon_e.bz_b),   mon_e.cyc);
        chk("rd_busy_nobyp",   96'(rd_busy_n),   96'(mon_e.bz_n),   mon_e.cyc);
        chk("stall_bypass",    96'(stall_b),     96'(mon_e.st),     mon_e.cyc);
        chk("stall_nobyp",     96'(stall_n),     96'(mon_e.st),     mon_e.cyc);
      end
    end
  end

  initial begin
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    // Reset contents visible while held in reset
    drive(1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd5, 4'd15, 4'd0);
    drive(1'b1, 4'd2, 1'b0, 4'd0, 32'd0, 1'b0, 4'd2, 4'd7, 4'd9);
    rst = 1'b1;
    // Write with same-cycle read, then read after the edge
    drive(1'b0, 4'd0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd3, 4'd4, 4'd3);
    drive(1'b0, 4'd0, 1'b0, 4'd0, 32'd0,        1'b0, 4'd3, 4'd3, 4'd0);
    // Two issues to r7, two writebacks
    drive(1'b1, 4'd7, 1'b0, 4'd0, 32'd0,   1'b0, 4'd7, 4'd0, 4'd0);
    drive(1'b1, 4'd7, 1'b0, 4'd0, 32'd0,   1'b0, 4'd7, 4'd7, 4'd0);
    drive(1'b0, 4'd0, 1'b1, 4'd7, 32'h111, 1'b0, 4'd7, 4'd7, 4'd7);
    drive(1'b0, 4'd0, 1'b1, 4'd7, 32'h222, 1'b0, 4'd7, 4'd7, 4'd7);
    drive(1'b0, 4'd0, 1'b0, 4'd0, 32'd0,   1'b0, 4'd7, 4'd0, 4'd0);
    // Saturation of r2, stalled fourth issue alongside a writeback
    drive(1'b1, 4'd2, 1'b0, 4'd0, 32'd0,   1'b0, 4'd2, 4'd0, 4'd0);
    drive(1'b1, 4'd2, 1'b0, 4'd0, 32'd0,   1'b0, 4'd2, 4'd0, 4'd0);
    drive(1'b1, 4'd2, 1'b0, 4'd0, 32'd0,   1'b0, 4'd2, 4'd0, 4'd0);
    drive(1'b1, 4'd2, 1'b1, 4'd2, 32'h333, 1'b0, 4'd2, 4'd2, 4'd0);
    drive(1'b0, 4'd0, 1'b1, 4'd2, 32'h444, 1'b0, 4'd2, 4'd0, 4'd0);
    drive(1'b0, 4'd0, 1'b1, 4'd2, 32'h555, 1'b0, 4'd2, 4'd0, 4'd0);
    drive(1'b0, 4'd0, 1'b0, 4'd0, 32'd0,   1'b0, 4'd2, 4'd0, 4'd0);
    // Flush together with a writeback
    drive(1'b1, 4'd4, 1'b0, 4'd0, 32'd0,  1'b0, 4'd4, 4'd9, 4'd0);
    drive(1'b1, 4'd4, 1'b0, 4'd0, 32'd0,  1'b0, 4'd4, 4'd9, 4'd0);
    drive(1'b1, 4'd9, 1'b0, 4'd0, 32'd0,  1'b0, 4'd4, 4'd9, 4'd0);
    drive(1'b0, 4'd0, 1'b1, 4'd4, 32'h55, 1'b1, 4'd4, 4'd9, 4'd0);
    drive(1'b0, 4'd0, 1'b0, 4'd0, 32'd0,  1'b0, 4'd4, 4'd9, 4'd0);
    // Stray writeback, then simultaneous issue and writeback at count 1
    drive(1'b0, 4'd0, 1'b1, 4'd6, 32'h1234, 1'b0, 4'd6, 4'd0, 4'd0);
    drive(1'b0, 4'd0, 1'b0, 4'd0, 32'd0,    1'b0, 4'd6, 4'd0, 4'd0);
    drive(1'b1, 4'd1, 1'b0, 4'd0, 32'd0,    1'b0, 4'd1, 4'd0, 4'd0);
    drive(1'b1, 4'd1, 1'b1, 4'd1, 32'hABCD, 1'b0, 4'd1, 4'd1, 4'd0);
    drive(1'b0, 4'd0, 1'b0, 4'd0, 32'd0,    1'b0, 4'd1, 4'd0, 4'd0);
    // Mid-run reset discards counts and data
    rst = 1'b0;
    model_reset();
    drive(1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd5, 4'd15, 4'd3);
    rst = 1'b1;
    // Randomized traffic concentrated on a few registers to provoke hazards
    for (int n = 0; n < 600; n++) begin
      logic [3:0] ra [3];
      for (int k = 0; k < 3; k++) begin
        ra[k] = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
      end
      if (n == 300) begin
        rst = 1'b0;
        model_reset();
      end
      if (n == 302) rst = 1'b1;
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), $urandom(),
            ($urandom_range(0, 31) == 0), ra[0], ra[1], ra[2]);
    end
    iss_en = 1'b0; wb_en = 1'b0; flush = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d predictions left, expected 0", q.size());
    end
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arm_regfile_sb.md
# arm_regfile_sb

Parametrised multi-read-port register file with an integrated per-register writeback scoreboard, used by the ARM pipeline's ID stage. It serves NUM_RD combinational reads per cycle and takes one writeback per cycle from the WB stage. It can optionally forward same-cycle writeback data to the read ports. Per-register pending-write counters report read-after-write hazards to the hazard unit, so a separate hazard comparator chain is not needed.

## Interface
- DATA_W, 32: register width in bits
- ADDR_W, 4: register address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 3: number of read ports
- CNT_W, 2: width of each register's pending-write counter
- BYPASS, 1: 1 = same-cycle writeback forwarded to reads; 0 = no forwarding
- RESET_MODE, 1: 0 = registers reset to 0; 1 = register i resets to value i
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, same packing as rd_addr
- rd_busy  out  NUM_RD  1 = register addressed by port k has a pending write
- iss_en  in  1  an instruction writing iss_addr is issued this cycle
- iss_addr  in  ADDR_W  destination register of the issued instruction
- iss_stall  out  1  1 = iss_addr counter saturated; the issue must not be accepted
- wb_en  in  1  writeback enable
- wb_addr  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback value
- flush  in  1  clear all pending counters (pipeline squash)

## Operation
- Storage: DEPTH x DATA_W array, plus one CNT_W-bit counter cnt[i] per register.
- Write: on posedge with wb_en=1, data[wb_addr] <= wb_data. There is no write protection; any address may be written.
- Read: rd_data[k] = data[rd_addr[k]], combinational.
  - With BYPASS=1, wb_en=1 and wb_addr==rd_addr[k], rd_data[k] = wb_data instead.
- Counter update per register i at posedge. inc = iss_en & iss_addr==i & ~iss_stall; dec = wb_en & wb_addr==i & cnt[i]!=0.
  - inc & ~dec: cnt+1
  - dec & ~inc: cnt-1
  - both or neither: unchanged
- Stray writeback (cnt==0): data is written and the counter stays 0. There is no underflow.
- iss_stall = iss_en & (cnt[iss_addr] == 2**CNT_W-1), combinational. A stalled issue does not change the counter.
  - A same-cycle writeback to that register does not clear the stall.
- flush=1: every counter goes to 0 at posedge and overrides inc/dec. The data write still happens if wb_en=1.
- rd_busy[k] = cnt[rd_addr[k]] != 0. The exception is when BYPASS=1, wb_en=1, wb_addr==rd_addr[k] and cnt==1: rd_busy[k]=0, because the forwarded value is the last pending result.
- Multiple read ports may address the same register; each port is independent.

## Timing
- Reset (rst=0, async): data[i] = 0 or i per RESET_MODE; all cnt = 0. Consequently rd_busy=0 and iss_stall=0. rd_data follows the reset contents combinationally.
  - Reset asserted mid-operation discards pending counts and in-flight writes immediately.
  - Deassertion is synchronised externally; the first update is at the first posedge with rst=1.
- Read latency:
  - 0 cycles from rd_addr to rd_data.
  - Write-to-read: 0 cycles with BYPASS=1; 1 cycle (visible after the posedge) with BYPASS=0.
- Issue/writeback: a counter incremented at edge N shows rd_busy=1 from edge N onward.
- Simultaneous iss and wb to the same register with cnt=1: cnt stays 1, and rd_busy stays 1 even with BYPASS, because a new write is pending.
- Counter saturation at 2**CNT_W-1 (3 by default). A fourth in-flight issue to the same register asserts iss_stall.

## Test plan
- Reset, RESET_MODE=1: drop rst to 0 mid-run -> rd_data reads r5=5 and r15=15 immediately; all rd_busy=0.
- Write/bypass: wb r3=0xDEADBEEF while reading r3 on port 0 -> with BYPASS=1, port 0 = 0xDEADBEEF in the same cycle; with BYPASS=0, the old value, then 0xDEADBEEF after the posedge.
- Scoreboard: issue r7 twice -> cnt=2 and rd_busy=1. One wb r7 -> still busy. Second wb r7 -> rd_busy=0 after the edge; with BYPASS, 0 during the wb cycle.
- Saturation: issue r2 three times, then a fourth with a wb to r2 in the same cycle -> iss_stall=1 and cnt becomes 2, not 3.
- Flush plus write: cnt[4]=2, cnt[9]=1; assert flush with wb r4=0x55 -> all rd_busy=0 next cycle and r4 reads 0x55.
- Stray and simultaneous: wb r6 with cnt=0 -> data written, cnt stays 0. With cnt[1]=1, iss r1 and wb r1 in the same cycle -> cnt stays 1 and rd_busy[r1]=1.
